// File: rtl/vram_console_if.sv
// Byte-stream input and VRAM write-port bundle for vram_console.
interface vram_console_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [9:0] v_ada;
  logic       v_cea;
  logic [7:0] v_din;
  logic [5:0] cur_col;
  logic [4:0] cur_row;

  modport master (
    output in_valid, in_data,
    input  in_ready, v_ada, v_cea, v_din, cur_col, cur_row
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, v_ada, v_cea, v_din, cur_col, cur_row
  );
endinterface

// File: rtl/vram_console.sv
// Character-stream terminal engine: decodes a byte stream into VRAM writes
// with cursor tracking, line wrap, per-row clear and full-screen clear.
module vram_console #(
  parameter int         COLS  = 60,
  parameter int         ROWS  = 17,
  parameter logic [7:0] BLANK = 8'h20
) (
  input logic           clk,
  input logic           rst,
  vram_console_if.slave bus
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam logic [9:0]  COLS_A = 10'(COLS);

  typedef enum logic [1:0] {INIT_CLR, IDLE, CLR_ROW, CLR_ALL} state_t;

  state_t     r_state, nxt_state;
  logic [5:0] r_col, nxt_col;
  logic [4:0] r_row, nxt_row;
  logic [9:0] r_base, nxt_base;
  logic [9:0] r_clr_addr, nxt_clr_addr;
  logic [5:0] r_clr_cnt, nxt_clr_cnt;
  logic       r_ready, nxt_ready;
  logic       r_cea, nxt_cea;
  logic [9:0] r_ada, nxt_ada;
  logic [7:0] r_din, nxt_din;

  logic       w_accept;
  logic       w_last_row;
  logic [9:0] w_adv_base;
  logic [4:0] w_adv_row;
  logic [9:0] w_cell;

  assign w_accept   = bus.in_valid && r_ready;
  assign w_last_row = (r_row == 5'(ROWS - 1));
  assign w_adv_base = w_last_row ? '0 : r_base + COLS_A;
  assign w_adv_row  = w_last_row ? '0 : r_row + 1'b1;
  assign w_cell     = r_base + 10'(r_col);

  always_comb begin
    nxt_state    = r_state;
    nxt_col      = r_col;
    nxt_row      = r_row;
    nxt_base     = r_base;
    nxt_clr_addr = r_clr_addr;
    nxt_clr_cnt  = r_clr_cnt;
    nxt_ready    = 1'b0;
    nxt_cea      = 1'b0;
    nxt_ada      = r_ada;
    nxt_din      = r_din;
    case (r_state)
      INIT_CLR, CLR_ALL: begin
        nxt_cea = 1'b1;
        nxt_ada = r_clr_addr;
        nxt_din = BLANK;
        if (r_clr_addr == 10'(CELLS - 1)) nxt_state = IDLE;
        else nxt_clr_addr = r_clr_addr + 1'b1;
      end
      CLR_ROW: begin
        nxt_cea = 1'b1;
        nxt_ada = r_clr_addr;
        nxt_din = BLANK;
        if (r_clr_cnt == 6'(COLS - 1)) begin
          nxt_state = IDLE;
        end else begin
          nxt_clr_addr = r_clr_addr + 1'b1;
          nxt_clr_cnt  = r_clr_cnt + 1'b1;
        end
      end
      IDLE: begin
        // Ready drops for one extra cycle after any clear because it is only
        // raised from a cycle that was already IDLE.
        nxt_ready = 1'b1;
        if (w_accept) begin
          case (bus.in_data)
            8'h0D: nxt_col = '0;
            8'h0A: begin
              nxt_col      = '0;
              nxt_row      = w_adv_row;
              nxt_base     = w_adv_base;
              nxt_cea      = 1'b1;
              nxt_ada      = w_adv_base;
              nxt_din      = BLANK;
              nxt_clr_addr = w_adv_base + 1'b1;
              nxt_clr_cnt  = 6'd1;
              nxt_state    = CLR_ROW;
              nxt_ready    = 1'b0;
            end
            8'h08: begin
              if (r_col != '0) begin
                nxt_col = r_col - 1'b1;
                nxt_cea = 1'b1;
                nxt_ada = w_cell - 1'b1;
                nxt_din = BLANK;
              end
            end
            8'h0C: begin
              nxt_col      = '0;
              nxt_row      = '0;
              nxt_base     = '0;
              nxt_cea      = 1'b1;
              nxt_ada      = '0;
              nxt_din      = BLANK;
              nxt_clr_addr = 10'd1;
              nxt_state    = CLR_ALL;
              nxt_ready    = 1'b0;
            end
            default: begin
              nxt_cea = 1'b1;
              nxt_ada = w_cell;
              nxt_din = bus.in_data;
              if (r_col == 6'(COLS - 1)) begin
                nxt_col      = '0;
                nxt_row      = w_adv_row;
                nxt_base     = w_adv_base;
                nxt_clr_addr = w_adv_base;
                nxt_clr_cnt  = '0;
                nxt_state    = CLR_ROW;
                nxt_ready    = 1'b0;
              end else begin
                nxt_col = r_col + 1'b1;
              end
            end
          endcase
        end
      end
      default: nxt_state = INIT_CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT_CLR;
      r_col      <= '0;
      r_row      <= '0;
      r_base     <= '0;
      r_clr_addr <= '0;
      r_clr_cnt  <= '0;
      r_ready    <= 1'b0;
      r_cea      <= 1'b0;
      r_ada      <= '0;
      r_din      <= '0;
    end else begin
      r_state    <= nxt_state;
      r_col      <= nxt_col;
      r_row      <= nxt_row;
      r_base     <= nxt_base;
      r_clr_addr <= nxt_clr_addr;
      r_clr_cnt  <= nxt_clr_cnt;
      r_ready    <= nxt_ready;
      r_cea      <= nxt_cea;
      r_ada      <= nxt_ada;
      r_din      <= nxt_din;
    end
  end

  assign bus.in_ready = r_ready;
  assign bus.v_cea    = r_cea;
  assign bus.v_ada    = r_ada;
  assign bus.v_din    = r_din;
  assign bus.cur_col  = r_col;
  assign bus.cur_row  = r_row;

endmodule

// File: tb/tb_vram_console.sv
// Bench for vram_console: per-cycle scoreboard against a write-list model,
// a vector table, hand-written corner sequences and random traffic.
module tb_vram_console;
  localparam int         COLS  = 60;
  localparam int         ROWS  = 17;
  localparam logic [7:0] BLANK = 8'h20;
  localparam int         CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_console_if bus();

  vram_console #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] d;
    bit         we;
    int         addr;
    logic [7:0] din;
    int         col;
    int         row;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  wr_t  q[$];
  int   m_col, m_row, busy, m_ada, m_din;
  bit   init_pend;
  bit   last_acc;
  vec_t vt[12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic push_row();
    for (int i = 0; i < COLS; i++) q.push_back(wr_t'{10'(m_row * COLS + i), BLANK});
  endtask

  // Model of a byte's effect, written straight from the decoding rules.
  task automatic model_accept(input logic [7:0] d);
    case (d)
      8'h0D: m_col = 0;
      8'h0A: begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push_row();
        busy = COLS;
      end
      8'h08: if (m_col > 0) begin
        m_col--;
        q.push_back(wr_t'{10'(m_row * COLS + m_col), BLANK});
      end
      8'h0C: begin
        m_col = 0;
        m_row = 0;
        for (int i = 0; i < CELLS; i++) q.push_back(wr_t'{10'(i), BLANK});
        busy = CELLS;
      end
      default: begin
        q.push_back(wr_t'{10'(m_row * COLS + m_col), d});
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
          push_row();
          busy = COLS + 1;
        end
      end
    endcase
  endtask

  task automatic tick();
    logic       acc, r, exp_cea;
    logic [7:0] d;
    wr_t        w;
    acc = bus.in_valid && bus.in_ready;
    d   = bus.in_data;
    r   = rst;
    @(posedge clk);
    #1;
    last_acc = acc && !r;
    exp_cea  = 1'b0;
    if (r) begin
      q.delete();
      m_col = 0; m_row = 0; busy = CELLS + 1; init_pend = 1'b1;
      m_ada = 0; m_din = 0;
    end else begin
      if (init_pend) begin
        for (int i = 0; i < CELLS; i++) q.push_back(wr_t'{10'(i), BLANK});
        init_pend = 1'b0;
      end
      if (busy > 0) busy--;
      if (acc) model_accept(d);
      if (q.size() > 0) begin
        w = q.pop_front();
        m_ada = int'(w.a);
        m_din = int'(w.d);
        exp_cea = 1'b1;
      end
    end
    chk("v_cea", int'(bus.v_cea), int'(exp_cea));
    chk("v_ada", int'(bus.v_ada), m_ada);
    chk("v_din", int'(bus.v_din), m_din);
    chk("in_ready", int'(bus.in_ready), (busy == 0) ? 1 : 0);
    chk("cur_col", int'(bus.cur_col), m_col);
    chk("cur_row", int'(bus.cur_row), m_row);
  endtask

  // Presents a byte and holds it until the DUT takes it.
  task automatic send(input logic [7:0] d, output int k);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_acc && k < 1200);
    if (!last_acc) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  int k, n, n_we, kr;
  logic [7:0] rb;

  initial begin
    vt[0]  = '{8'h41, 1'b1, 0,  8'h41, 1, 0};
    vt[1]  = '{8'h42, 1'b1, 1,  8'h42, 2, 0};
    vt[2]  = '{8'h0D, 1'b0, 0,  8'h00, 0, 0};
    vt[3]  = '{8'h08, 1'b0, 0,  8'h00, 0, 0};
    vt[4]  = '{8'h43, 1'b1, 0,  8'h43, 1, 0};
    vt[5]  = '{8'h08, 1'b1, 0,  BLANK, 0, 0};
    vt[6]  = '{8'h44, 1'b1, 0,  8'h44, 1, 0};
    vt[7]  = '{8'h45, 1'b1, 1,  8'h45, 2, 0};
    vt[8]  = '{8'h08, 1'b1, 1,  BLANK, 1, 0};
    vt[9]  = '{8'h0A, 1'b1, 60, BLANK, 0, 1};
    vt[10] = '{8'h46, 1'b1, 60, 8'h46, 1, 1};
    vt[11] = '{8'h0C, 1'b1, 0,  BLANK, 0, 0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset and power-on clear.
    repeat (3) tick();
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_cea", int'(bus.v_cea), 0);
    rst = 1'b0;
    k = 0; n_we = 0;
    do begin
      tick();
      k++;
      if (bus.v_cea) n_we++;
    end while (!bus.in_ready && k < 2000);
    chk("init_ready_cycle", k, CELLS + 1);
    chk("init_write_count", n_we, CELLS);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      send(vt[i].d, k);
      chk($sformatf("vec%0d_cea", i), int'(bus.v_cea), int'(vt[i].we));
      if (vt[i].we) begin
        chk($sformatf("vec%0d_ada", i), int'(bus.v_ada), vt[i].addr);
        chk($sformatf("vec%0d_din", i), int'(bus.v_din), int'(vt[i].din));
      end
      chk($sformatf("vec%0d_col", i), int'(bus.cur_col), vt[i].col);
      chk($sformatf("vec%0d_row", i), int'(bus.cur_row), vt[i].row);
    end

    // "AB" back to back from (0,0).
    send(8'h41, k);
    send(8'h42, k);
    chk("ab_b_latency", k, 1);
    chk("ab_ready", int'(bus.in_ready), 1);
    chk("ab_col", int'(bus.cur_col), 2);

    // Full row of glyphs wraps and blanks the next row.
    send(8'h0C, k);
    for (int i = 0; i < COLS; i++) send(8'h58, k);
    n = 0;
    while (!bus.in_ready && n < 2000) begin
      n++;
      tick();
    end
    chk("wrap_stall", n, COLS + 1);
    chk("wrap_row", int'(bus.cur_row), 1);
    chk("wrap_col", int'(bus.cur_col), 0);

    // LF on the last row wraps to row 0; CR afterwards is free.
    send(8'h0C, k);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, k);
    for (int i = 0; i < 5; i++) send(8'h61, k);
    chk("r16_row", int'(bus.cur_row), 16);
    chk("r16_col", int'(bus.cur_col), 5);
    send(8'h0A, k);
    chk("lf16_ada", int'(bus.v_ada), 0);
    chk("lf16_row", int'(bus.cur_row), 0);
    n = 0;
    while (!bus.in_ready && n < 2000) begin
      n++;
      tick();
    end
    chk("lf_stall", n, COLS);
    send(8'h0D, k);
    chk("cr_cea", int'(bus.v_cea), 0);
    chk("cr_ready", int'(bus.in_ready), 1);

    // Backspace at (2,3) and at (2,0).
    send(8'h0C, k);
    send(8'h0A, k); send(8'h0A, k);
    for (int i = 0; i < 3; i++) send(8'h62, k);
    send(8'h08, k);
    chk("bs_cea", int'(bus.v_cea), 1);
    chk("bs_ada", int'(bus.v_ada), 122);
    chk("bs_col", int'(bus.cur_col), 2);
    send(8'h0D, k);
    send(8'h08, k);
    chk("bs0_cea", int'(bus.v_cea), 0);
    chk("bs0_col", int'(bus.cur_col), 0);
    chk("bs0_row", int'(bus.cur_row), 2);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 63);
      if (n == 0)      rb = 8'h0C;
      else if (n < 5)  rb = 8'h0A;
      else if (n < 8)  rb = 8'h0D;
      else if (n < 13) rb = 8'h08;
      else             rb = 8'($urandom_range(8'h21, 8'h7E));
      repeat ($urandom_range(0, 2)) tick();
      send(rb, k);
    end

    // Reset in the middle of a full clear while a byte is held.
    repeat (1100) begin
      if (bus.in_ready) break;
      tick();
    end
    send(8'h0C, k);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h51;
    n = 0;
    repeat (500) begin
      tick();
      if (last_acc) n++;
    end
    chk("held_not_taken", n, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    k = 0; kr = 0;
    do begin
      tick();
      k++;
      if (bus.in_ready && kr == 0) kr = k;
    end while (!last_acc && k < 2000);
    bus.in_valid = 1'b0;
    chk("rst_mid_ready_cycle", kr, CELLS + 1);
    chk("rst_mid_accept_cycle", k, CELLS + 2);
    chk("rst_mid_ada", int'(bus.v_ada), 0);
    chk("rst_mid_din", int'(bus.v_din), 8'h51);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
